// File: rtl/sample_frame_packer_pkg.sv
// Shared definitions for the sample frame packer: FSM state encoding and
// the frame sync byte.
package sample_frame_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_CAPT,
    ST_MSB,
    ST_LSB,
    ST_CNT,
    ST_CHK
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/sample_frame_packer.sv
// Drains 16-bit samples from the upstream FIFO and emits framed bytes:
// sync, N x {MSB, LSB}, count N, checksum (two's complement of the byte sum).
module sample_frame_packer
  import sample_frame_packer_pkg::*;
#(
  parameter int g_MaxSamples    = 16,
  parameter int g_TimeoutCycles = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Enable,
  input  logic        i_SampleEmpty,
  output logic        o_SampleRead,
  input  logic [15:0] i_SampleData,
  output logic        o_ByteValid,
  input  logic        i_ByteReady,
  output logic [7:0]  o_ByteData,
  output logic        o_FrameActive,
  output logic [15:0] o_FrameCount
);

  localparam int               TIMER_W    = $clog2(g_TimeoutCycles + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(g_TimeoutCycles - 1);
  localparam logic [7:0]       MAX_N      = 8'(g_MaxSamples);

  state_e               state_q, state_d;
  logic [7:0]           n_q, n_d;
  logic [7:0]           acc_q, acc_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [15:0]          sample_q, sample_d;
  logic                 byte_valid_q, byte_valid_d;
  logic [7:0]           byte_data_q, byte_data_d;
  logic                 frame_active_q, frame_active_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 sample_read;
  logic                 accept;

  assign accept = byte_valid_q && i_ByteReady;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    acc_d         = acc_q;
    timer_d       = timer_q;
    sample_d      = sample_q;
    frame_count_d = frame_count_q;
    sample_read   = 1'b0;

    // Every accepted byte after sync feeds the checksum, count byte included.
    if (accept && state_q != ST_HDR) begin
      acc_d = acc_q + byte_data_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_Enable && !i_SampleEmpty) begin
          state_d = ST_HDR;
          n_d     = '0;
          acc_d   = '0;
          timer_d = '0;
        end
      end
      ST_HDR: begin
        if (accept) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // A waiting sample wins over both the idle timeout and a disable.
        if (!i_SampleEmpty && n_q < MAX_N) begin
          sample_read = 1'b1;
          timer_d     = '0;
          state_d     = ST_CAPT;
        end else if (!i_Enable || (n_q != 8'd0 && timer_q == TIMER_LAST)) begin
          state_d = ST_CNT;
        end else if (n_q != 8'd0) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_CAPT: begin
        sample_d = i_SampleData;
        state_d  = ST_MSB;
      end
      ST_MSB: begin
        if (accept) state_d = ST_LSB;
      end
      ST_LSB: begin
        if (accept) begin
          n_d     = n_q + 8'd1;
          state_d = (n_q + 8'd1 == MAX_N) ? ST_CNT : ST_FETCH;
        end
      end
      ST_CNT: begin
        if (accept) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (accept) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output byte is a function of the next state, so it is stable while stalled.
  always_comb begin
    byte_valid_d   = 1'b0;
    byte_data_d    = 8'd0;
    frame_active_d = (state_d != ST_IDLE);
    case (state_d)
      ST_HDR: begin
        byte_valid_d = 1'b1;
        byte_data_d  = SYNC_BYTE;
      end
      ST_MSB: begin
        byte_valid_d = 1'b1;
        byte_data_d  = sample_d[15:8];
      end
      ST_LSB: begin
        byte_valid_d = 1'b1;
        byte_data_d  = sample_d[7:0];
      end
      ST_CNT: begin
        byte_valid_d = 1'b1;
        byte_data_d  = n_d;
      end
      ST_CHK: begin
        byte_valid_d = 1'b1;
        byte_data_d  = 8'd0 - acc_d;
      end
      default: begin
        byte_valid_d = 1'b0;
        byte_data_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      acc_q          <= '0;
      timer_q        <= '0;
      sample_q       <= '0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= '0;
      frame_active_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      acc_q          <= acc_d;
      timer_q        <= timer_d;
      sample_q       <= sample_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      frame_active_q <= frame_active_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign o_SampleRead  = sample_read;
  assign o_ByteValid   = byte_valid_q;
  assign o_ByteData    = byte_data_q;
  assign o_FrameActive = frame_active_q;
  assign o_FrameCount  = frame_count_q;

endmodule
